window_linebuffer: RTL and testbench

- Upstream stage of the per-class inner-product units in the logistic-regression path.
- Takes a raster-order stream of PW-bit grayscale pixels and holds K-1 previous image lines in line buffers.
- Emits every valid KxK window as an 81-entry pixel array, which all classifier inner-product instances consume in parallel.
- Outputs are registered; the block has one pixel/cycle throughput and tolerates gaps in the input stream.

---
 rtl/window_linebuffer_pkg.sv | 22 ++
 rtl/window_linebuffer_line_ram.sv | 27 ++
 rtl/window_linebuffer.sv | 129 ++++++++++++
 tb/tb_window_linebuffer.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/window_linebuffer_pkg.sv
// Shared types and default geometry for the logistic-regression front end.
// The window line buffer and its testbench both import this package.
package lr_pkg;

    localparam int PW    = 7;
    localparam int K     = 9;
    localparam int IMG_W = 28;
    localparam int IMG_H = 28;

    // Number of complete KxK windows in one frame.
    localparam int WIN_PER_FRAME = (IMG_H - K + 1) * (IMG_W - K + 1);

    typedef logic [PW-1:0] pixel_t;
    typedef pixel_t [0:K*K-1] window_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/window_linebuffer_line_ram.sv
// One image line of pixel storage with a single shared address.
// A read and a write at the same address in one cycle returns the old data.
module line_ram #(
    parameter int DEPTH = 28,
    parameter int WIDTH = 7,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    // The window register samples this in the same cycle the column is
    // overwritten, so the read must see the pre-write contents.
    assign dout = mem[addr];

endmodule

// File: rtl/window_linebuffer.sv
// Raster-order pixel stream to KxK sliding window, with K-1 line stores.
// Emits one registered window per accepted pixel once the window is complete.
module window_linebuffer
    import lr_pkg::*;
#(
    parameter int IMG_W = lr_pkg::IMG_W,
    parameter int IMG_H = lr_pkg::IMG_H,
    parameter int K     = lr_pkg::K,
    parameter int PW    = lr_pkg::PW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [PW-1:0]            pix_in,
    input  logic                     pix_valid,
    input  logic                     sof,
    output logic [PW-1:0]            xarray [0:K*K-1],
    output logic                     win_valid,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic                     frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int NL = K - 1;

    state_t          state_reg;
    logic [CW-1:0]   col_reg;
    logic [RW-1:0]   row_reg;
    logic [PW-1:0]   win_reg [0:K*K-1];

    logic            accept;
    logic            last_px;
    logic            win_ok;
    logic [CW-1:0]   proc_col;
    logic [RW-1:0]   proc_row;
    logic [PW-1:0]   lb_in   [0:NL-1];
    logic [PW-1:0]   lb_out  [0:NL-1];
    logic [PW-1:0]   new_col [0:K-1];

    // sof wins in every state: it restarts the frame at (0,0).
    assign accept   = pix_valid && (sof || (state_reg == ST_ACTIVE));
    assign proc_col = sof ? '0 : col_reg;
    assign proc_row = sof ? '0 : row_reg;
    assign last_px  = (proc_row == RW'(IMG_H - 1)) && (proc_col == CW'(IMG_W - 1));
    assign win_ok   = (proc_row >= RW'(K - 1)) && (proc_col >= CW'(K - 1));

    // Line stores form a vertical shift chain: lb[0] is the newest line.
    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_line
            if (gi == 0) begin : g_head
                assign lb_in[gi] = pix_in;
            end else begin : g_tail
                assign lb_in[gi] = lb_out[gi-1];
            end

            line_ram #(
                .DEPTH (IMG_W),
                .WIDTH (PW)
            ) u_line (
                .clk  (clk),
                .we   (accept),
                .addr (proc_col),
                .din  (lb_in[gi]),
                .dout (lb_out[gi])
            );

            // Window row 0 is the oldest line, held in the last store.
            assign new_col[gi] = lb_out[NL-1-gi];
        end
    endgenerate

    assign new_col[K-1] = pix_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            col_reg    <= '0;
            row_reg    <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            for (int i = 0; i < K*K; i++) begin
                win_reg[i] <= '0;
            end
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (accept) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K-1; c++) begin
                        win_reg[r*K+c] <= win_reg[r*K+c+1];
                    end
                    win_reg[r*K+K-1] <= new_col[r];
                end

                // Windows that straddle a line wrap are never flagged valid.
                if (win_ok) begin
                    win_valid  <= 1'b1;
                    win_row    <= proc_row - RW'(K - 1);
                    win_col    <= proc_col - CW'(K - 1);
                    frame_done <= last_px;
                end

                if (last_px) begin
                    col_reg   <= '0;
                    row_reg   <= '0;
                    state_reg <= ST_DONE;
                end else if (proc_col == CW'(IMG_W - 1)) begin
                    col_reg   <= '0;
                    row_reg   <= proc_row + 1'b1;
                    state_reg <= ST_ACTIVE;
                end else begin
                    col_reg   <= proc_col + 1'b1;
                    row_reg   <= proc_row;
                    state_reg <= ST_ACTIVE;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < K*K; gi++) begin : g_out
            assign xarray[gi] = win_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_window_linebuffer.sv
// Randomized bench for window_linebuffer against an image-array reference model.
// Each accepted pixel is stored at its raster position; windows are cut from that image.
module tb_window_linebuffer;
    import lr_pkg::*;

    localparam int RWB = $clog2(IMG_H);
    localparam int CWB = $clog2(IMG_W);
    localparam int XB  = K*K*PW;

    typedef struct packed {
        logic          v;
        logic          s;
        logic [PW-1:0] p;
    } stim_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [PW-1:0]  pix_in;
    logic           pix_valid;
    logic           sof;
    logic [PW-1:0]  xarray [0:K*K-1];
    logic           win_valid;
    logic [RWB-1:0] win_row;
    logic [CWB-1:0] win_col;
    logic           frame_done;

    window_linebuffer dut (
        .clk        (clk),
        .rst        (rst),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .xarray     (xarray),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nwin;
    int ndone;

    // Reference model state
    logic [PW-1:0]  img [0:IMG_H-1][0:IMG_W-1];
    logic           m_active;
    int             m_row;
    int             m_col;
    logic           exp_valid;
    logic           exp_done;
    logic [RWB-1:0] exp_row;
    logic [CWB-1:0] exp_col;
    logic [XB-1:0]  exp_flat;

    stim_t stim_q[$];

    function automatic logic [XB-1:0] pack_x();
        logic [XB-1:0] f;
        for (int k = 0; k < K*K; k++) begin
            f[k*PW +: PW] = xarray[k];
        end
        return f;
    endfunction

    // Build npix pixels of a frame in raster order, sof on the first, with random idle gaps.
    task automatic gen_frame(input int gap_pct, input bit pattern, input int npix);
        stim_t st;
        for (int i = 0; i < npix; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                st.v = 1'b0;
                st.s = 1'($urandom);
                st.p = PW'($urandom);
                stim_q.push_back(st);
            end
            st.v = 1'b1;
            st.s = (i == 0);
            st.p = pattern ? PW'(((i / IMG_W) * 28 + (i % IMG_W)) % 128) : PW'($urandom);
            stim_q.push_back(st);
        end
    endtask

    task automatic gen_nosof(input int n);
        stim_t st;
        for (int i = 0; i < n; i++) begin
            st.v = 1'($urandom_range(0, 3) != 0);
            st.s = 1'b0;
            st.p = PW'($urandom);
            stim_q.push_back(st);
        end
    endtask

    // Drive one cycle and compute what the outputs must be just after the edge.
    task automatic step(input stim_t st);
        pix_valid = st.v;
        sof       = st.s;
        pix_in    = st.p;
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (st.v && (st.s || m_active)) begin
            if (st.s) begin
                m_row    = 0;
                m_col    = 0;
                m_active = 1'b1;
            end
            img[m_row][m_col] = st.p;
            if (m_row >= K-1 && m_col >= K-1) begin
                exp_valid = 1'b1;
                exp_row   = RWB'(m_row - (K-1));
                exp_col   = CWB'(m_col - (K-1));
                exp_done  = (m_row == IMG_H-1) && (m_col == IMG_W-1);
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K; j++) begin
                        exp_flat[(i*K+j)*PW +: PW] = img[m_row-(K-1)+i][m_col-(K-1)+j];
                    end
                end
            end
            if (m_col == IMG_W-1) begin
                m_col = 0;
                if (m_row == IMG_H-1) m_active = 1'b0;
                else m_row++;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_valid = 1'b0; sof = 1'b0; pix_in = '0;
        m_active = 1'b0; m_row = 0; m_col = 0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
            bad++; $display("FAIL reset_flags got=%b%b want=00", win_valid, frame_done);
        end
        total++;
        if (win_row !== '0 || win_col !== '0) begin
            bad++; $display("FAIL reset_coords got=%0d,%0d want=0,0", win_row, win_col);
        end
        total++;
        if (pack_x() !== '0) begin
            bad++; $display("FAIL reset_xarray got=%h want=0", pack_x());
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_continuous();
        int cyc = 0;
        int first_cyc = -1;
        logic [PW-1:0] f0 = '0, f80 = '0;
        logic [RWB-1:0] fr = '0;
        logic [CWB-1:0] fc = '0;
        nwin = 0; ndone = 0;
        gen_frame(0, 1'b1, IMG_W*IMG_H);
        while (stim_q.size() > 0) begin
            step(stim_q.pop_front());
            total++;
            if (win_valid !== exp_valid) begin
                bad++; $display("FAIL cont_valid got=%b want=%b t=%0t", win_valid, exp_valid, $time);
            end
            total++;
            if (exp_valid && {win_row, win_col, frame_done} !== {exp_row, exp_col, exp_done}) begin
                bad++; $display("FAIL cont_coords got=%0d,%0d,%b want=%0d,%0d,%b", win_row, win_col, frame_done, exp_row, exp_col, exp_done);
            end else if (!exp_valid && frame_done !== 1'b0) begin
                bad++; $display("FAIL cont_done got=%b want=0", frame_done);
            end
            if (exp_valid) begin
                total++;
                if (pack_x() !== exp_flat) begin
                    bad++; $display("FAIL cont_xarray got=%h want=%h", pack_x(), exp_flat);
                end
            end
            if (win_valid === 1'b1 && nwin == 0) begin
                first_cyc = cyc; f0 = xarray[0]; f80 = xarray[80]; fr = win_row; fc = win_col;
            end
            if (win_valid === 1'b1) nwin++;
            if (frame_done === 1'b1) ndone++;
            cyc++;
        end
        total++;
        if (first_cyc != 8*IMG_W + 8 || fr !== '0 || fc !== '0) begin
            bad++; $display("FAIL cont_first_win got=cyc%0d (%0d,%0d) want=cyc%0d (0,0)", first_cyc, fr, fc, 8*IMG_W+8);
        end
        total++;
        if (f0 !== 7'd0 || f80 !== 7'd104) begin
            bad++; $display("FAIL cont_first_pix got=%0d,%0d want=0,104", f0, f80);
        end
        total++;
        if (nwin != WIN_PER_FRAME || ndone != 1) begin
            bad++; $display("FAIL cont_count got=%0d/%0d want=%0d/1", nwin, ndone, WIN_PER_FRAME);
        end
    endtask

    task automatic test_gaps();
        nwin = 0; ndone = 0;
        gen_frame(40, 1'b1, IMG_W*IMG_H);
        while (stim_q.size() > 0) begin
            step(stim_q.pop_front());
            total++;
            if (win_valid !== exp_valid) begin
                bad++; $display("FAIL gaps_valid got=%b want=%b t=%0t", win_valid, exp_valid, $time);
            end
            if (exp_valid) begin
                total++;
                if ({win_row, win_col, frame_done} !== {exp_row, exp_col, exp_done}) begin
                    bad++; $display("FAIL gaps_coords got=%0d,%0d,%b want=%0d,%0d,%b", win_row, win_col, frame_done, exp_row, exp_col, exp_done);
                end
                total++;
                if (pack_x() !== exp_flat) begin
                    bad++; $display("FAIL gaps_xarray got=%h want=%h", pack_x(), exp_flat);
                end
            end
            if (win_valid === 1'b1) nwin++;
            if (frame_done === 1'b1) ndone++;
        end
        total++;
        if (nwin != WIN_PER_FRAME || ndone != 1) begin
            bad++; $display("FAIL gaps_count got=%0d/%0d want=%0d/1", nwin, ndone, WIN_PER_FRAME);
        end
    endtask

    task automatic test_no_sof();
        nwin = 0; ndone = 0;
        gen_nosof(120);
        while (stim_q.size() > 0) begin
            step(stim_q.pop_front());
            if (win_valid === 1'b1) nwin++;
            if (frame_done === 1'b1) ndone++;
        end
        total++;
        if (nwin != 0 || ndone != 0) begin
            bad++; $display("FAIL nosof_quiet got=%0d/%0d want=0/0", nwin, ndone);
        end
    endtask

    task automatic test_abort();
        nwin = 0; ndone = 0;
        gen_frame(10, 1'b0, 12*IMG_W + 5);
        gen_frame(10, 1'b0, IMG_W*IMG_H);
        while (stim_q.size() > 0) begin
            step(stim_q.pop_front());
            total++;
            if (win_valid !== exp_valid) begin
                bad++; $display("FAIL abort_valid got=%b want=%b t=%0t", win_valid, exp_valid, $time);
            end
            if (exp_valid) begin
                total++;
                if ({win_row, win_col, frame_done} !== {exp_row, exp_col, exp_done}) begin
                    bad++; $display("FAIL abort_coords got=%0d,%0d,%b want=%0d,%0d,%b", win_row, win_col, frame_done, exp_row, exp_col, exp_done);
                end
                total++;
                if (pack_x() !== exp_flat) begin
                    bad++; $display("FAIL abort_xarray got=%h want=%h", pack_x(), exp_flat);
                end
            end
            if (win_valid === 1'b1) nwin++;
            if (frame_done === 1'b1) ndone++;
        end
        // The aborted frame's sof lands on pixel (12,5): rows 8..11 give 4*20 windows.
        total++;
        if (nwin != 80 + WIN_PER_FRAME || ndone != 1) begin
            bad++; $display("FAIL abort_count got=%0d/%0d want=%0d/1", nwin, ndone, 80 + WIN_PER_FRAME);
        end
    endtask

    task automatic test_reset_mid();
        gen_frame(0, 1'b0, 15*IMG_W + 21);
        while (stim_q.size() > 0) begin
            step(stim_q.pop_front());
        end
        total++;
        if (win_valid !== 1'b1 || win_row !== RWB'(7) || win_col !== CWB'(12)) begin
            bad++; $display("FAIL rstmid_before got=%b (%0d,%0d) want=1 (7,12)", win_valid, win_row, win_col);
        end
        #2 rst = 1'b1;
        m_active = 1'b0;
        #1;
        total++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_row !== '0 || win_col !== '0) begin
            bad++; $display("FAIL rstmid_outputs got=%b%b (%0d,%0d) want=00 (0,0)", win_valid, frame_done, win_row, win_col);
        end
        total++;
        if (pack_x() !== '0) begin
            bad++; $display("FAIL rstmid_xarray got=%h want=0", pack_x());
        end
        #2 rst = 1'b0;
        nwin = 0; ndone = 0;
        gen_nosof(80);
        gen_frame(20, 1'b0, IMG_W*IMG_H);
        while (stim_q.size() > 0) begin
            step(stim_q.pop_front());
            total++;
            if (win_valid !== exp_valid) begin
                bad++; $display("FAIL rstmid_valid got=%b want=%b t=%0t", win_valid, exp_valid, $time);
            end
            if (exp_valid) begin
                total++;
                if ({win_row, win_col, frame_done} !== {exp_row, exp_col, exp_done}) begin
                    bad++; $display("FAIL rstmid_coords got=%0d,%0d,%b want=%0d,%0d,%b", win_row, win_col, frame_done, exp_row, exp_col, exp_done);
                end
                total++;
                if (pack_x() !== exp_flat) begin
                    bad++; $display("FAIL rstmid_xarray2 got=%h want=%h", pack_x(), exp_flat);
                end
            end
            if (win_valid === 1'b1) nwin++;
            if (frame_done === 1'b1) ndone++;
        end
        total++;
        if (nwin != WIN_PER_FRAME || ndone != 1) begin
            bad++; $display("FAIL rstmid_count got=%0d/%0d want=%0d/1", nwin, ndone, WIN_PER_FRAME);
        end
    endtask

    task automatic test_back_to_back();
        nwin = 0; ndone = 0;
        gen_frame(0, 1'b0, IMG_W*IMG_H);
        gen_frame(0, 1'b0, IMG_W*IMG_H);
        while (stim_q.size() > 0) begin
            step(stim_q.pop_front());
            total++;
            if (win_valid !== exp_valid) begin
                bad++; $display("FAIL b2b_valid got=%b want=%b t=%0t", win_valid, exp_valid, $time);
            end
            if (exp_valid) begin
                total++;
                if ({win_row, win_col, frame_done} !== {exp_row, exp_col, exp_done}) begin
                    bad++; $display("FAIL b2b_coords got=%0d,%0d,%b want=%0d,%0d,%b", win_row, win_col, frame_done, exp_row, exp_col, exp_done);
                end
                total++;
                if (pack_x() !== exp_flat) begin
                    bad++; $display("FAIL b2b_xarray got=%h want=%h", pack_x(), exp_flat);
                end
            end
            if (win_valid === 1'b1) nwin++;
            if (frame_done === 1'b1) ndone++;
        end
        total++;
        if (nwin != 2*WIN_PER_FRAME || ndone != 2) begin
            bad++; $display("FAIL b2b_count got=%0d/%0d want=%0d/2", nwin, ndone, 2*WIN_PER_FRAME);
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_no_sof();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        pix_valid = 1'b0;
        sof = 1'b0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
